// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and helpers for the WS2812 strip driver.
//   ws2812_state_t : wire/frame sequencing states
//   ns_to_cyc      : nanoseconds -> clock cycles (floored, minimum 1)
//   PIXEL_W        : bits per pixel on the wire (GRB, 8 bits each)
package ws2812_pkg;

    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_LATCH = 2'd3
    } ws2812_state_t;

    // Divide the clock down to kHz first so the product stays small.
    function automatic int ns_to_cyc(input int clk_fre, input int ns);
        longint c;
        c = (longint'(clk_fre) / 64'sd1000 * longint'(ns)) / 64'sd1000000;
        if (c < 64'sd1) begin
            c = 64'sd1;
        end else begin
            c = c;
        end
        return int'(c);
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: produces the HIGH/LOW waveform of one WS2812 bit.
//   clk, reset_n : clock, synchronous active-low reset
//   go, bit_in   : start a bit (accepted in IDLE or in the last LOW cycle)
//   dout         : registered data line
//   bit_done     : high during the last LOW cycle of a bit; a go in that
//                  same cycle chains the next bit with no gap
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = 10,
    parameter int T0L_CYC = 22,
    parameter int T1H_CYC = 22,
    parameter int T1L_CYC = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic go,
    input  logic bit_in,
    output logic dout,
    output logic bit_done
);

    localparam int MAX_A   = (T0H_CYC > T0L_CYC) ? T0H_CYC : T0L_CYC;
    localparam int MAX_B   = (T1H_CYC > T1L_CYC) ? T1H_CYC : T1L_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);

    ws2812_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hi_last_s, lo_last_s;
    logic          bit_q, bit_d;
    logic          dout_q, dout_d;
    logic          bit_done_s;

    // Next-state logic for the high/low phase sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        bit_done_s = 1'b0;
        hi_last_s  = bit_q ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
        lo_last_s  = bit_q ? CW'(T1L_CYC - 1) : CW'(T0L_CYC - 1);
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    bit_d   = bit_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (cnt_q == hi_last_s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOW: begin
                if (cnt_q == lo_last_s) begin
                    bit_done_s = 1'b1;
                    cnt_d      = '0;
                    if (go) begin
                        state_d = ST_HIGH;
                        bit_d   = bit_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Line follows the phase we are entering, so it is glitch-free.
        dout_d = (state_d == ST_HIGH);
    end

    // Phase, counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            dout_q  <= dout_d;
        end
    end

    assign dout     = dout_q;
    assign bit_done = bit_done_s;

endmodule

// File: rtl/ws2812_strip.sv
// ws2812_strip: LED_COUNT x 24-bit pixel buffer serialised onto a WS2812 line.
//   clk, reset_n        : clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data : host pixel write (out-of-range addresses ignored)
//   start               : frame trigger, sampled in IDLE
//   dout                : WS2812 data line
//   busy                : frame or latch gap in progress
//   done                : one-cycle pulse after each frame's latch gap
module ws2812_strip
    import ws2812_pkg::*;
#(
    parameter int   LED_COUNT   = 8,
    parameter int   CLK_FRE     = 27_000_000,
    parameter int   T0H_NS      = 400,
    parameter int   T0L_NS      = 850,
    parameter int   T1H_NS      = 850,
    parameter int   T1L_NS      = 400,
    parameter int   LATCH_US    = 80,
    parameter int   AUTO_REPEAT = 0,
    localparam int  AW          = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               start,
    output logic               dout,
    output logic               busy,
    output logic               done
);

    localparam int T0H_CYC   = ns_to_cyc(CLK_FRE, T0H_NS);
    localparam int T0L_CYC   = ns_to_cyc(CLK_FRE, T0L_NS);
    localparam int T1H_CYC   = ns_to_cyc(CLK_FRE, T1H_NS);
    localparam int T1L_CYC   = ns_to_cyc(CLK_FRE, T1L_NS);
    localparam int LATCH_CYC = CLK_FRE / 1_000_000 * LATCH_US;
    localparam int LW        = $clog2(LATCH_CYC + 1);

    localparam logic [AW-1:0] PIX_LAST   = AW'(LED_COUNT - 1);
    localparam logic [AW:0]   LED_CNT_X  = (AW + 1)'(LED_COUNT);
    localparam logic [4:0]    BIT_LAST   = 5'(PIXEL_W - 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);

    // ST_HIGH is held for the whole bit stream; the per-bit HIGH/LOW
    // phases are sequenced inside ws2812_bit_tx.
    ws2812_state_t      state_q, state_d;
    logic [PIXEL_W-1:0] shift_q, shift_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]      latch_cnt_q, latch_cnt_d;
    logic               fetch_q, fetch_d;
    logic               boot_q, boot_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [PIXEL_W-1:0] rd_data_q, rd_data_d;
    logic [PIXEL_W-1:0] mem_q [LED_COUNT];

    logic               load_pix_s, go_s, go_bit_s, tx_done_s, tx_dout_s;
    logic               rd_en_s;
    logic [AW-1:0]      next_pix_s, rd_addr_s;

    ws2812_bit_tx #(
        .T0H_CYC(T0H_CYC),
        .T0L_CYC(T0L_CYC),
        .T1H_CYC(T1H_CYC),
        .T1L_CYC(T1L_CYC)
    ) u_bit_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (go_s),
        .bit_in  (go_bit_s),
        .dout    (tx_dout_s),
        .bit_done(tx_done_s)
    );

    // Frame sequencing, bit/pixel counters and prefetch control.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        latch_cnt_d = latch_cnt_q;
        boot_d      = boot_q;
        done_d      = 1'b0;
        load_pix_s  = 1'b0;
        go_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || (AUTO_REPEAT != 0)) begin
                    state_d    = ST_HIGH;
                    load_pix_s = 1'b1;
                    pix_cnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (tx_done_s) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (pix_cnt_q == PIX_LAST) begin
                            state_d     = ST_LATCH;
                            latch_cnt_d = '0;
                        end else begin
                            load_pix_s = 1'b1;
                            pix_cnt_d  = pix_cnt_q + AW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        shift_d   = {shift_q[PIXEL_W-2:0], 1'b0};
                        go_s      = 1'b1;
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LATCH: begin
                if (latch_cnt_q == LATCH_LAST) begin
                    latch_cnt_d = '0;
                    boot_d      = 1'b0;
                    // The gap that follows reset is not a frame end.
                    done_d      = ~boot_q;
                    if (AUTO_REPEAT != 0) begin
                        state_d    = ST_HIGH;
                        load_pix_s = 1'b1;
                        pix_cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    latch_cnt_d = latch_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d     = ST_LATCH;
                latch_cnt_d = '0;
            end
        endcase
        // A new pixel comes straight from the prefetch register, and the
        // following cycle fetches the pixel after it.
        if (load_pix_s) begin
            shift_d   = rd_data_q;
            bit_cnt_d = '0;
            go_s      = 1'b1;
            fetch_d   = 1'b1;
        end else begin
            fetch_d = 1'b0;
        end
        go_bit_s = shift_d[PIXEL_W-1];
        busy_d   = (state_d != ST_IDLE);
        // Outside a frame keep pixel 0 staged for the next start.
        next_pix_s = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + AW'(1);
        rd_en_s    = fetch_q || (state_q != ST_HIGH);
        rd_addr_s  = fetch_q ? next_pix_s : '0;
        rd_data_d  = rd_en_s ? mem_q[rd_addr_s] : rd_data_q;
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_LATCH;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            latch_cnt_q <= '0;
            fetch_q     <= 1'b0;
            boot_q      <= 1'b1;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            fetch_q     <= fetch_d;
            boot_q      <= boot_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Pixel buffer: not cleared by reset, read-first against the prefetch.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < LED_CNT_X)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign dout = tx_dout_s;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ws2812_strip.sv
// Directed bench for ws2812_strip: one 2-LED manual-start instance and one
// 3-LED auto-repeat instance, both at 27 MHz default timings.
module tb_ws2812_strip;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, wr_en, start, wr_en_a;
    logic [0:0]  wr_addr;
    logic [1:0]  wr_addr_a;
    logic [23:0] wr_data, wr_data_a;
    logic        dout, busy, done, dout_a, busy_a, done_a;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    int          cap_k, cap_wr_at;
    logic [23:0] cap_wr_val;

    always @(posedge clk) cyc <= cyc + 1;

    ws2812_strip #(.LED_COUNT(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .dout(dout), .busy(busy), .done(done)
    );

    ws2812_strip #(.LED_COUNT(3), .AUTO_REPEAT(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .start(start), .dout(dout_a), .busy(busy_a), .done(done_a)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic dsel(input bit s);
        return s ? dout_a : dout;
    endfunction

    // One capture cycle; optionally writes pixel 1 of the manual instance.
    task automatic cap_step();
        @(negedge clk);
        cap_k++;
        if (cap_k == cap_wr_at) begin
            wr_en = 1'b1; wr_addr = 1'b1; wr_data = cap_wr_val;
        end else begin
            wr_en = 1'b0;
        end
    endtask

    // Decode n bits starting at (or waiting for) a rising edge.
    task automatic capture(input bit s, input int n, output logic [71:0] bits,
                           output int bad_hi, output int bad_per, output bit tmo);
        bits = '0; bad_hi = 0; bad_per = 0; tmo = 1'b0; cap_k = 0;
        for (int i = 0; i < n; i++) begin
            int hi = 0, lo = 0, w = 0;
            while (dsel(s) !== 1'b1 && w < 100) begin cap_step(); w++; end
            if (w >= 100) tmo = 1'b1;
            while (dsel(s) === 1'b1 && hi < 100) begin hi++; cap_step(); end
            if (i < n - 1)
                while (dsel(s) === 1'b0 && lo < 100) begin lo++; cap_step(); end
            bits[n-1-i] = (hi == 22);
            if (hi != 22 && hi != 10) bad_hi++;
            if (i < n - 1 && hi + lo != 32) bad_per++;
        end
    endtask

    // Advance to the done pulse, counting cycles and anomalies on the way.
    task automatic wait_done(input bit s, output int lows, output int busy_drops, output int highs);
        lows = 0; busy_drops = 0; highs = 0;
        while ((s ? done_a : done) !== 1'b1 && lows < 5000) begin
            if ((s ? busy_a : busy) !== 1'b1) busy_drops++;
            if (dsel(s) !== 1'b0) highs++;
            lows++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n, bad;
        reset_n = 1'b0; start = 1'b0;
        wr_en = 1'b1; wr_addr = 1'b0; wr_data = 24'hF00001;
        wr_en_a = 1'b1; wr_addr_a = 2'd0; wr_data_a = 24'h123456;
        @(negedge clk);
        wr_addr = 1'b1; wr_data = 24'h000000;
        wr_addr_a = 2'd1; wr_data_a = 24'hABCDEF;
        @(negedge clk);
        wr_en = 1'b0;
        wr_addr_a = 2'd2; wr_data_a = 24'h800000;
        @(negedge clk);
        wr_en_a = 1'b0;
        vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL reset_dout: got %b want 0", dout); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        reset_n = 1'b1;
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 5000) begin
            if (done !== 1'b0 || dout !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        vectors++; if (n != 2160) begin miscompares++; $display("FAIL reset_gap_len: got %0d want 2160", n); end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL reset_gap_quiet: got %0d bad cycles want 0", bad); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_no_done: got %b want 0", done); end
    endtask

    task automatic run_frame(input string nm, input logic [47:0] exp_bits, input int exp_lows);
        logic [71:0] bits; int bh, bp, lows, bd, hh; bit tmo;
        cap_wr_at = -1;
        capture(1'b0, 48, bits, bh, bp, tmo);
        vectors++; if (bits[47:0] !== exp_bits) begin miscompares++; $display("FAIL %s_bits: got %h want %h", nm, bits[47:0], exp_bits); end
        vectors++; if (bh != 0 || bp != 0 || tmo != 1'b0) begin miscompares++; $display("FAIL %s_timing: got hi=%0d per=%0d tmo=%0d want 0 0 0", nm, bh, bp, tmo); end
        wait_done(1'b0, lows, bd, hh);
        vectors++; if (lows != exp_lows) begin miscompares++; $display("FAIL %s_latch_len: got %0d want %0d", nm, lows, exp_lows); end
        vectors++; if (bd != 0 || hh != 0) begin miscompares++; $display("FAIL %s_latch_state: got busy_drops=%0d highs=%0d want 0 0", nm, bd, hh); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_at_done: got %b want 0", nm, busy); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL %s_done_width: got %b want 0", nm, done); end
    endtask

    task automatic test_single_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (dout !== 1'b1) begin miscompares++; $display("FAIL start_latency_dout: got %b want 1", dout); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start_latency_busy: got %b want 1", busy); end
        run_frame("single", 48'hF00001_000000, 2182);
    endtask

    task automatic test_write_during_frame();
        logic [71:0] bits; int bh, bp, lows, bd, hh; bit tmo;
        start = 1'b1; wr_en = 1'b1; wr_addr = 1'b1; wr_data = 24'hFFFFFF;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        cap_wr_at = 808; cap_wr_val = 24'h000000;
        capture(1'b0, 48, bits, bh, bp, tmo);
        vectors++; if (bits[47:0] !== 48'hF00001_FFFFFF) begin miscompares++; $display("FAIL wdf_bits: got %h want f00001ffffff", bits[47:0]); end
        vectors++; if (bh != 0 || bp != 0 || tmo != 1'b0) begin miscompares++; $display("FAIL wdf_timing: got hi=%0d per=%0d tmo=%0d want 0 0 0", bh, bp, tmo); end
        wait_done(1'b0, lows, bd, hh);
        vectors++; if (lows != 2170) begin miscompares++; $display("FAIL wdf_latch_len: got %0d want 2170", lows); end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_frame("wdf_next", 48'hF00001_000000, 2182);
    endtask

    task automatic test_ignored_start();
        logic [71:0] bits; int bh, bp, lows, bd, hh, bad; bit tmo;
        int unsigned t0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        cap_wr_at = -1;
        capture(1'b0, 4, bits, bh, bp, tmo);
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, lows, bd, hh);
        vectors++; if (cyc - t0 != 3696) begin miscompares++; $display("FAIL frame_length: got %0d want 3696", cyc - t0); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL start_while_busy: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_mid_frame_reset();
        int n, bad;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (325) @(negedge clk);
        vectors++; if (dout !== 1'b1) begin miscompares++; $display("FAIL mid_bit10_high: got %b want 1", dout); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL mid_reset_dout: got %b want 0", dout); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_reset_busy: got %b want 1", busy); end
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 5000) begin
            if (done !== 1'b0 || dout !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        vectors++; if (n != 2160 || bad != 0) begin miscompares++; $display("FAIL mid_reset_gap: got len=%0d bad=%0d want 2160 0", n, bad); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (dout !== 1'b1) begin miscompares++; $display("FAIL mid_restart_dout: got %b want 1", dout); end
        run_frame("mid_restart", 48'hF00001_000000, 2182);
    endtask

    task automatic test_auto_repeat();
        logic [71:0] bits; int bh, bp, lows, bd, hh, n; bit tmo;
        int unsigned t0;
        n = 0;
        while (done_a !== 1'b1 && n < 12000) begin n++; @(negedge clk); end
        vectors++; if (n >= 12000) begin miscompares++; $display("FAIL auto_first_done: got timeout want done pulse"); end
        t0 = cyc;
        vectors++; if (dout_a !== 1'b1 || busy_a !== 1'b1) begin miscompares++; $display("FAIL auto_restart: got dout=%b busy=%b want 1 1", dout_a, busy_a); end
        cap_wr_at = -1;
        capture(1'b1, 72, bits, bh, bp, tmo);
        vectors++; if (bits !== 72'h123456_ABCDEF_800000) begin miscompares++; $display("FAIL auto_bits: got %h want 123456abcdef800000", bits); end
        vectors++; if (bh != 0 || bp != 0 || tmo != 1'b0) begin miscompares++; $display("FAIL auto_timing: got hi=%0d per=%0d tmo=%0d want 0 0 0", bh, bp, tmo); end
        wr_en_a = 1'b1; wr_addr_a = 2'd3; wr_data_a = 24'hAAAAAA;
        @(negedge clk);
        wr_en_a = 1'b0;
        wait_done(1'b1, lows, bd, hh);
        // Last bit is a 0 (22 low) plus the gap, less the write cycle above.
        vectors++; if (lows != 2181) begin miscompares++; $display("FAIL auto_gap: got %0d want 2181", lows); end
        vectors++; if (bd != 0 || hh != 0) begin miscompares++; $display("FAIL auto_busy_hold: got drops=%0d highs=%0d want 0 0", bd, hh); end
        vectors++; if (cyc - t0 != 4464) begin miscompares++; $display("FAIL auto_period: got %0d want 4464", cyc - t0); end
        vectors++; if (dout_a !== 1'b1 || busy_a !== 1'b1) begin miscompares++; $display("FAIL auto_restart2: got dout=%b busy=%b want 1 1", dout_a, busy_a); end
        capture(1'b1, 72, bits, bh, bp, tmo);
        vectors++; if (bits !== 72'h123456_ABCDEF_800000) begin miscompares++; $display("FAIL auto_oob_write: got %h want 123456abcdef800000", bits); end
    endtask

    initial begin
        wr_en = 1'b0; wr_addr = 1'b0; wr_data = '0;
        wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        cap_wr_at = -1; cap_wr_val = '0; cap_k = 0;
        test_reset();
        test_single_frame();
        test_write_during_frame();
        test_ignored_start();
        test_mid_frame_reset();
        test_auto_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ws2812_strip.md
# ws2812_strip

Parametrised WS2812 strip driver: holds a `LED_COUNT`-deep, 24-bit pixel buffer written by the host side and serialises it onto a single-wire output. Each frame is started by a trigger or by an automatic repeat, and is followed by a latch (reset) gap. Bit timings are derived from nanosecond parameters and the clock frequency. The block sits between the status/indicator logic and the board LED pin, replacing the fixed-pattern single-LED driver.

## Interface

- `LED_COUNT`, 8: number of LEDs in the chain (≥1).
- `CLK_FRE`, 27_000_000: clock frequency in Hz.
- `T0H_NS`, 400: high time for a 0 bit.
- `T0L_NS`, 850: low time for a 0 bit.
- `T1H_NS`, 850: high time for a 1 bit.
- `T1L_NS`, 400: low time for a 1 bit.
- `LATCH_US`, 80: low gap after each frame (≥50).
- `AUTO_REPEAT`, 0: 1 = start the next frame immediately after each latch gap; `start` is ignored.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, **synchronous, active-low**.
- `wr_en`  in  1  pixel write strobe.
- `wr_addr`  in  AW = max(1, $clog2(LED_COUNT))  pixel index (0 = first LED on the wire).
- `wr_data`  in  24  pixel word, already in wire order (GRB packed by caller); sent MSB first.
- `start`  in  1  frame trigger, level-sampled in IDLE.
- `dout`  out  1  WS2812 data line.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` pulses; also high during the post-reset latch gap.
- `done`  out  1  one-cycle pulse at the end of each frame's latch gap.

## Operation

- Cycle counts: `X_CYC = max(1, (CLK_FRE/1000 * X_NS) / 1_000_000)`, integer, rounded down. For the latch gap: `LATCH_CYC = CLK_FRE/1_000_000 * LATCH_US`. At 27 MHz this gives T0H=10, T0L=22, T1H=22, T1L=10, LATCH=2160 cycles.
- FSM states: IDLE, HIGH, LOW, LATCH.
- **IDLE:** `dout`=0. If `start`=1 (or `AUTO_REPEAT`), go to HIGH with bit 23 of pixel 0 loaded.
- **HIGH:** `dout`=1 for T1H_CYC or T0H_CYC cycles, depending on the current bit. Then go to LOW.
- **LOW:** `dout`=0 for T1L_CYC or T0L_CYC cycles. Then:
  - next bit → HIGH;
  - after bit 0 of the last pixel → LATCH.
- **LATCH:** `dout`=0 for LATCH_CYC cycles. Then pulse `done` and go to IDLE (or straight to HIGH if `AUTO_REPEAT`).
- Pixel fetch: the buffer has a registered read. Pixel k+1 is prefetched during the first HIGH cycle of pixel k. The shift register reloads from the prefetch register with no added cycle, so there is no gap between pixels.
- Write rules:
  - Writes are accepted in every state.
  - `wr_addr` ≥ `LED_COUNT` is ignored.
  - A write to the pixel being read in the same cycle returns old data (read-first).
  - A write to a pixel after its fetch takes effect in the next frame.
- `start` while `busy` is ignored; no queuing.
- Buffer contents are not cleared by reset.

## Timing

- Reset values: `dout`=0, `busy`=1, `done`=0, state LATCH, counters 0.
- After reset, the block runs one LATCH_CYC gap with no `done` pulse, then `busy`=0 in IDLE. This guarantees the strip sees a latch before any frame.
- Reset asserted mid-frame: at the next edge `dout`=0 and the frame is abandoned. The post-reset gap still applies.
- Start latency: `start` high at edge N in IDLE gives `dout`=1 and `busy`=1 from edge N+1.
- Bit period is exactly TxH_CYC + TxL_CYC cycles.
- Frame length is `LED_COUNT`×24 bit periods + LATCH_CYC cycles.
- `done` is high for one cycle, in the cycle after the last LATCH cycle. `busy` falls in the same cycle, unless `AUTO_REPEAT`, in which case `busy` stays high.
- Edge case `LED_COUNT`=1: the prefetch targets pixel 0 again, which is harmless.

## Structure

- Package `ws2812_pkg`: state enum `ws2812_state_t`, function `ns_to_cyc(clk_fre, ns)`, and constant `PIXEL_W`=24.
- Sub-module `ws2812_bit_tx`: takes one bit plus a `go` strobe, produces the HIGH/LOW waveform, and returns `bit_done`. The top level owns the pixel buffer, prefetch, bit/pixel counters and the LATCH/IDLE sequencing.

## Test plan

- **Reset:** hold `reset_n`=0 for 3 cycles, then release → `dout`=0, `busy`=1 for 2160 cycles then 0, no `done` pulse.
- **Single frame:** `LED_COUNT`=2, write pixel0=24'hF00001 and pixel1=24'h000000, pulse `start` → 48 bits. Pixel 0 decodes as four 1s, nineteen 0s, one 1. High widths are 22 or 10 cycles, periods are all 32. Then 2160 low cycles and one `done` pulse.
- **Write during frame:** during pixel 0, write pixel1=24'hFFFFFF → sent this frame. During pixel 1, write pixel1=0 → not sent until the next frame.
- **Ignored inputs:** `start` while `busy` → no effect. Write with `wr_addr`=LED_COUNT → buffer unchanged.
- **Mid-frame reset:** `reset_n`=0 during bit 10 → `dout`=0 next edge, full latch gap follows, next `start` sends the frame from pixel 0.
- **Auto repeat:** `AUTO_REPEAT`=1 → consecutive frames separated by exactly 2160 low cycles, `done` pulses once per frame, `busy` stays 1.
